// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-and-add multiplier controller for the calculator's multiply path.
// Accepts an operand pair on start/ready, iterates WIDTH cycles, then pulses done for one cycle.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_result;
  logic               r_overflow;

  // Accumulator value after this cycle's partial product; also the final product on the last RUN edge.
  logic [2*WIDTH-1:0] w_sum;
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, x};
            r_mplier <= y;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_product  <= w_sum;
            r_result   <= w_sum[WIDTH-1:0];
            r_overflow <= |w_sum[2*WIDTH-1:WIDTH];
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
  assign done     = (r_state == S_DONE);
  assign product  = r_product;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: vector table, random ops vs. arithmetic model, corner sequences.
module tb_mul_seq_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   result;
  logic           overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .result   (result),
    .overflow (overflow)
  );

  typedef struct {
    logic [W-1:0]   vx;
    logic [W-1:0]   vy;
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    logic           ov;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic [2*W-1:0] ep, input logic [W-1:0] er,
                        input logic eo, input string tag);
    int cyc;
    int bad;
    cyc = 0;
    bad = 0;
    check({tag, "_ready_pre"}, {31'd0, ready}, 32'd1);
    x = a;
    y = b;
    start = 1'b1;
    step();
    start = 1'b0;
    x = na;
    y = nb;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1 || ready !== 1'b0) bad++;
      step();
      cyc++;
    end
    check({tag, "_run_flags"}, bad, 0);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_done_flags"}, {29'd0, busy, ready, done}, 32'b101);
    check({tag, "_product"}, {24'd0, product}, {24'd0, ep});
    check({tag, "_result"}, {28'd0, result}, {28'd0, er});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    step();
    check({tag, "_idle_flags"}, {29'd0, busy, ready, done}, 32'b010);
    check({tag, "_product_hold"}, {24'd0, product}, {24'd0, ep});
  endtask

  initial begin
    int pr;
    int acc_q[$];
    int dones;
    int dbl;
    logic prev_done;
    logic [W-1:0] a;
    logic [W-1:0] b;

    vecs[0] = '{vx: 4'd3,  vy: 4'd5,  p: 8'h0F, r: 4'hF, ov: 1'b0};
    vecs[1] = '{vx: 4'd15, vy: 4'd15, p: 8'hE1, r: 4'h1, ov: 1'b1};
    vecs[2] = '{vx: 4'd8,  vy: 4'd2,  p: 8'h10, r: 4'h0, ov: 1'b1};
    vecs[3] = '{vx: 4'd0,  vy: 4'd9,  p: 8'h00, r: 4'h0, ov: 1'b0};
    vecs[4] = '{vx: 4'd1,  vy: 4'd15, p: 8'h0F, r: 4'hF, ov: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("reset_flags", {29'd0, busy, ready, done}, 32'b010);
      check("reset_outs", {19'd0, product, result, overflow}, 32'd0);
      step();
    end

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].vx, vecs[i].vy, vecs[i].vx, vecs[i].vy, vecs[i].p, vecs[i].r, vecs[i].ov, "vec");

    // Operand hold: x/y change right after the accepting edge.
    run_op(4'd7, 4'd6, 4'd1, 4'd1, 8'h2A, 4'hA, 1'b1, "hold");

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      pr = int'(a) * int'(b);
      run_op(a, b, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
             (2*W)'(pr), W'(pr % 16), pr >= 16, "rand");
    end

    // Start held high: accepts only on IDLE edges, one every W+2 cycles.
    x = 4'd2;
    y = 4'd3;
    start = 1'b1;
    dones = 0;
    dbl = 0;
    prev_done = 1'b0;
    for (int t = 0; t < 18; t++) begin
      if (ready === 1'b1) acc_q.push_back(t);
      step();
      if (done === 1'b1) begin
        dones++;
        if (prev_done === 1'b1) dbl++;
        check("b2b_product", {24'd0, product}, 32'h06);
      end
      if ((ready & busy) !== 1'b0) dbl++;
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_accepts", acc_q.size(), 3);
    for (int i = 0; i < acc_q.size(); i++)
      check("b2b_accept_edge", acc_q[i], i * (W + 2));
    check("b2b_dones", dones, 3);
    check("b2b_pulse_width", dbl, 0);
    while (ready !== 1'b1 && dones < 100) begin
      step();
      dones++;
    end

    // Reset on the 2nd RUN edge aborts 9x9 with no done pulse.
    x = 4'd9;
    y = 4'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_flags", {29'd0, busy, ready, done}, 32'b010);
    check("abort_outs", {19'd0, product, result, overflow}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0) dones++;
      step();
    end
    check("abort_no_done", dones, 0);
    run_op(4'd2, 4'd2, 4'd2, 4'd2, 8'h04, 4'h4, 1'b0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
